// File: rtl/scale_frame_sequencer.sv
// Frame-level sequencer for the RAM_RD -> DS -> US -> RAM_WR scaling pipeline.
// Raises stage run levels, collects dones, drains, and flags hung stages via a watchdog.
module scale_frame_sequencer #(
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int DRAIN_CYCLES   = 4,
  parameter int FCNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [1:0]        mode_i,
  output logic              ram_rd_run_o,
  input  logic              ram_rd_done_i,
  output logic              ds_run_o,
  input  logic              ds_done_i,
  output logic              us_run_o,
  input  logic              us_done_i,
  output logic              ram_wr_run_o,
  input  logic              ram_wr_done_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [FCNT_W-1:0] frame_cnt_o
);
  // state | meaning
  // IDLE  | waiting for start
  // PREP  | one cycle: clear seen flags, load watchdog
  // RUN   | stages running, collecting dones
  // DRAIN | runs dropped, pipeline flushing for DRAIN_CYCLES
  // DONE  | one cycle: done pulse, frame counted
  // ERR   | timeout or illegal mode, waiting for start/abort
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DR_W = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PREP, S_RUN, S_DRAIN, S_DONE, S_ERR
  } state_t;

  state_t          state;
  logic            mode_us;
  logic            seen_rd, seen_ds, seen_us, seen_wr;
  logic [WD_W-1:0] wd_cnt;
  logic [DR_W-1:0] drain_cnt;

  logic rd_nxt, ds_nxt, us_nxt, wr_nxt, all_done, mode_legal;

  // A done arriving together with the last other done still completes the set.
  assign rd_nxt     = seen_rd | ram_rd_done_i;
  assign ds_nxt     = seen_ds | ds_done_i;
  assign us_nxt     = seen_us | us_done_i;
  assign wr_nxt     = seen_wr | ram_wr_done_i;
  assign all_done   = rd_nxt & ds_nxt & wr_nxt & (us_nxt | ~mode_us);
  assign mode_legal = ~mode_i[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      mode_us      <= 1'b0;
      seen_rd      <= 1'b0;
      seen_ds      <= 1'b0;
      seen_us      <= 1'b0;
      seen_wr      <= 1'b0;
      wd_cnt       <= '0;
      drain_cnt    <= '0;
      ram_rd_run_o <= 1'b0;
      ds_run_o     <= 1'b0;
      us_run_o     <= 1'b0;
      ram_wr_run_o <= 1'b0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      err_o        <= 1'b0;
      frame_cnt_o  <= '0;
    end else begin
      done_o <= 1'b0;
      if (abort_i && state != S_IDLE) begin
        state        <= S_IDLE;
        ram_rd_run_o <= 1'b0;
        ds_run_o     <= 1'b0;
        us_run_o     <= 1'b0;
        ram_wr_run_o <= 1'b0;
        busy_o       <= 1'b0;
        err_o        <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_i) begin
              if (mode_legal) begin
                mode_us <= mode_i[0];
                busy_o  <= 1'b1;
                state   <= S_PREP;
              end else begin
                err_o <= 1'b1;
                state <= S_ERR;
              end
            end
          end
          S_PREP: begin
            seen_rd      <= 1'b0;
            seen_ds      <= 1'b0;
            seen_us      <= 1'b0;
            seen_wr      <= 1'b0;
            wd_cnt       <= WD_W'(TIMEOUT_CYCLES - 1);
            ram_rd_run_o <= 1'b1;
            ds_run_o     <= 1'b1;
            us_run_o     <= mode_us;
            ram_wr_run_o <= 1'b1;
            state        <= S_RUN;
          end
          S_RUN: begin
            seen_rd <= rd_nxt;
            seen_ds <= ds_nxt;
            seen_us <= us_nxt;
            seen_wr <= wr_nxt;
            // Completion beats a watchdog expiring on the same cycle.
            if (all_done || wd_cnt == '0) begin
              ram_rd_run_o <= 1'b0;
              ds_run_o     <= 1'b0;
              us_run_o     <= 1'b0;
              ram_wr_run_o <= 1'b0;
              if (all_done) begin
                drain_cnt <= DR_W'(DRAIN_CYCLES - 1);
                state     <= S_DRAIN;
              end else begin
                busy_o <= 1'b0;
                err_o  <= 1'b1;
                state  <= S_ERR;
              end
            end else begin
              wd_cnt <= wd_cnt - 1'b1;
            end
          end
          S_DRAIN: begin
            if (drain_cnt == '0) begin
              done_o      <= 1'b1;
              frame_cnt_o <= frame_cnt_o + 1'b1;
              state       <= S_DONE;
            end else begin
              drain_cnt <= drain_cnt - 1'b1;
            end
          end
          S_DONE: begin
            busy_o <= 1'b0;
            state  <= S_IDLE;
          end
          S_ERR: begin
            if (start_i && mode_legal) begin
              err_o   <= 1'b0;
              mode_us <= mode_i[0];
              busy_o  <= 1'b1;
              state   <= S_PREP;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_scale_frame_sequencer.sv
// Directed bench for scale_frame_sequencer; completed-frame counts are scoreboarded
// at frame start and checked when done_o pulses.
module tb_scale_frame_sequencer;
  localparam int TO = 100;
  localparam int DR = 4;
  localparam int FW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [1:0]    mode_i = 2'b00;
  logic          ram_rd_done_i = 1'b0;
  logic          ds_done_i = 1'b0;
  logic          us_done_i = 1'b0;
  logic          ram_wr_done_i = 1'b0;
  logic          ram_rd_run_o, ds_run_o, us_run_o, ram_wr_run_o;
  logic          busy_o, done_o, err_o;
  logic [FW-1:0] frame_cnt_o;

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int exp_cnt = 0;
  int sb[$];

  scale_frame_sequencer #(
    .TIMEOUT_CYCLES(TO), .DRAIN_CYCLES(DR), .FCNT_W(FW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i), .mode_i(mode_i),
    .ram_rd_run_o(ram_rd_run_o), .ram_rd_done_i(ram_rd_done_i),
    .ds_run_o(ds_run_o), .ds_done_i(ds_done_i),
    .us_run_o(us_run_o), .us_done_i(us_done_i),
    .ram_wr_run_o(ram_wr_run_o), .ram_wr_done_i(ram_wr_done_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL time_limit: observed no finish, expected finish");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_runs(input string tag, input logic rd, input logic ds,
                            input logic us, input logic wr);
    check(tag, {28'd0, ram_rd_run_o, ds_run_o, us_run_o, ram_wr_run_o}, {28'd0, rd, ds, us, wr});
  endtask

  task automatic clear_dones();
    ram_rd_done_i = 1'b0;
    ds_done_i     = 1'b0;
    us_done_i     = 1'b0;
    ram_wr_done_i = 1'b0;
  endtask

  // done_o sampled mid-cycle; each pulse must match the oldest expected count.
  always @(negedge clk) begin
    if (rst_n && done_o) begin
      done_seen++;
      check("done_expected", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) check("frame_cnt", {30'd0, frame_cnt_o}, sb.pop_front());
    end
  end

  // Full frame from IDLE/ERR; done offsets count RUN cycles from 1, 0 = never.
  task automatic frame(input logic [1:0] m, input int drd, input int dds,
                       input int dus, input int dwr);
    logic use_us;
    int   last;
    int   d0;
    use_us = (m == 2'b01);
    last = drd;
    if (dds > last) last = dds;
    if (dwr > last) last = dwr;
    if (use_us && dus > last) last = dus;
    sb.push_back((exp_cnt + 1) % 4);
    exp_cnt++;
    d0 = done_seen;
    start_i = 1'b1;
    mode_i  = m;
    step();
    mode_i = 2'b11;
    check("prep_busy", busy_o, 1);
    check("prep_err", err_o, 0);
    check_runs("prep_runs", 0, 0, 0, 0);
    step();
    check_runs("run_rise", 1, 1, use_us, 1);
    for (int i = 1; i <= last; i++) begin
      ram_rd_done_i = (i == drd);
      ds_done_i     = (i == dds);
      us_done_i     = (i == dus);
      ram_wr_done_i = (i == dwr);
      step();
      clear_dones();
      if (i < last) check_runs("run_hold", 1, 1, use_us, 1);
    end
    start_i = 1'b0;
    check_runs("drain_runs", 0, 0, 0, 0);
    check("drain_busy", busy_o, 1);
    for (int j = 1; j < DR; j++) begin
      step();
      check("drain_no_done", done_o, 0);
    end
    step();
    check("done_pulse", done_o, 1);
    check("done_busy", busy_o, 1);
    step();
    check("done_single", done_o, 0);
    check("idle_busy", busy_o, 0);
    check("done_count", done_seen, d0 + 1);
    mode_i = 2'b00;
  endtask

  initial begin
    int d0;
    // reset
    repeat (3) step();
    check("rst_outs", {23'd0, ram_rd_run_o, ds_run_o, us_run_o, ram_wr_run_o,
                       busy_o, done_o, err_o, frame_cnt_o}, 0);
    rst_n = 1'b1;
    step();

    // mode 01, staggered dones; mode 00 with us_done never asserted
    frame(2'b01, 10, 20, 30, 40);
    frame(2'b00, 5, 3, 0, 7);

    // watchdog: us_done withheld in mode 01
    d0 = done_seen;
    start_i = 1'b1;
    mode_i  = 2'b01;
    step();
    start_i = 1'b0;
    step();
    check_runs("to_run_rise", 1, 1, 1, 1);
    for (int i = 1; i < TO; i++) begin
      ram_rd_done_i = (i == 5);
      ds_done_i     = (i == 5);
      ram_wr_done_i = (i == 5);
      step();
      clear_dones();
      if (i == TO - 1) check_runs("to_still_run", 1, 1, 1, 1);
    end
    step();
    check("to_err", err_o, 1);
    check("to_busy", busy_o, 0);
    check_runs("to_runs", 0, 0, 0, 0);
    repeat (3) step();
    check("to_no_done", done_seen, d0);
    check("to_err_sticky", err_o, 1);
    frame(2'b00, 1, 1, 0, 1);

    // illegal mode
    start_i = 1'b1;
    mode_i  = 2'b11;
    step();
    start_i = 1'b0;
    check("ill_err", err_o, 1);
    check("ill_busy", busy_o, 0);
    check_runs("ill_runs", 0, 0, 0, 0);
    start_i = 1'b1;
    mode_i  = 2'b10;
    step();
    start_i = 1'b0;
    check("ill_err_stay", err_o, 1);
    check("ill_busy_stay", busy_o, 0);
    repeat (3) step();
    check_runs("ill_runs_low", 0, 0, 0, 0);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check("ill_abort_err", err_o, 0);
    check("ill_abort_busy", busy_o, 0);

    // abort mid-RUN
    d0 = done_seen;
    start_i = 1'b1;
    mode_i  = 2'b00;
    step();
    start_i = 1'b0;
    step();
    repeat (5) step();
    check_runs("ab_run", 1, 1, 0, 1);
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check_runs("ab_run_runs", 0, 0, 0, 0);
    check("ab_run_busy", busy_o, 0);
    check("ab_run_err", err_o, 0);
    repeat (DR + 3) step();
    check("ab_run_no_done", done_seen, d0);
    check("ab_run_cnt", {30'd0, frame_cnt_o}, exp_cnt % 4);

    // abort mid-DRAIN, all dones on the same cycle
    start_i = 1'b1;
    mode_i  = 2'b01;
    step();
    start_i = 1'b0;
    step();
    ram_rd_done_i = 1'b1;
    ds_done_i     = 1'b1;
    us_done_i     = 1'b1;
    ram_wr_done_i = 1'b1;
    step();
    clear_dones();
    check_runs("ab_dr_runs", 0, 0, 0, 0);
    check("ab_dr_busy", busy_o, 1);
    step();
    abort_i = 1'b1;
    step();
    abort_i = 1'b0;
    check("ab_dr_idle", busy_o, 0);
    repeat (DR + 3) step();
    check("ab_dr_no_done", done_seen, d0);
    check("ab_dr_cnt", {30'd0, frame_cnt_o}, exp_cnt % 4);

    // reset mid-RUN
    start_i = 1'b1;
    mode_i  = 2'b01;
    step();
    start_i = 1'b0;
    step();
    check_runs("rst_run", 1, 1, 1, 1);
    rst_n = 1'b0;
    step();
    check("rst_mid_outs", {23'd0, ram_rd_run_o, ds_run_o, us_run_o, ram_wr_run_o,
                           busy_o, done_o, err_o, frame_cnt_o}, 0);
    rst_n = 1'b1;
    exp_cnt = 0;
    step();

    // four back-to-back frames, counter wraps 1,2,3,0
    frame(2'b00, 1, 1, 0, 1);
    frame(2'b01, 1, 1, 1, 1);
    frame(2'b00, 2, 1, 0, 1);
    frame(2'b01, 1, 2, 3, 2);
    check("wrap_cnt", {30'd0, frame_cnt_o}, 0);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
